// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone pipelined arbiter (round-robin) with an outstanding-strobe limit.
// Latency: one cycle from cyc to grant; once owned, requests and responses pass through combinationally.
// Backpressure: non-owner always stalled; owner stalled by the slave or while MAX_OUTSTANDING strobes are in flight.
// Optional bus watchdog is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // master 0 (core data port)
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_stall_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    // master 1 (debug/DMA port)
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_stall_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    // shared bus towards the address decoder
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_stall_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Zero-sized limits would make the arbiter unable to ever forward or time out.
    if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_arbiter2: MAX_OUTSTANDING and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;     // master that wins a simultaneous request
    logic [CNT_W-1:0] cnt_q, cnt_d;       // accepted but unanswered strobes

    logic        owned;
    logic        own_sel;
    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_dat;
    logic [3:0]  own_be;
    logic        cnt_full;
    logic        hold;
    logic        accept;
    logic        resp;
    logic        timeout;
    logic        wd_block;

    assign owned    = (state_q == OWN0) || (state_q == OWN1);
    assign own_sel  = (state_q == OWN1);
    assign cnt_full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign hold     = cnt_full || wd_block;
    assign resp     = s_ack_i || s_err_i;
    assign accept   = owned && own_stb && !hold && !s_stall_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_armed;
    logic            wd_last;

    assign wd_armed = owned && (cnt_q != '0);
    assign wd_last  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    // Last silent cycle: stop new strobes so nothing is accepted into a bus about to abort.
    assign wd_block = wd_armed && wd_last;
    assign timeout  = wd_armed && wd_last && !resp;

    // Count consecutive response-free cycles while something is outstanding.
    always_comb begin
        wd_d = '0;
        if (wd_armed && !resp && !wd_last) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_block = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Select the current owner's request signals.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_be  = '0;
        if (owned) begin
            if (own_sel) begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_be  = m1_sel_i;
            end else begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_be  = m0_sel_i;
            end
        end
    end

    // Drive the shared bus from the owner and route responses back to it only.
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_dat_o   = '0;
        m1_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_dat_o   = '0;
        grant_o    = 2'b00;
        if (owned) begin
            s_cyc_o = own_cyc;
            s_stb_o = own_stb && !hold;
            s_we_o  = own_we;
            s_adr_o = own_adr;
            s_dat_o = own_dat;
            s_sel_o = own_be;
            // A simultaneous ack and err is reported as an error only.
            if (own_sel) begin
                grant_o    = 2'b10;
                m1_stall_o = s_stall_i || hold;
                m1_ack_o   = s_ack_i && !s_err_i;
                m1_err_o   = s_err_i || timeout;
                m1_dat_o   = s_dat_i;
            end else begin
                grant_o    = 2'b01;
                m0_stall_o = s_stall_i || hold;
                m0_ack_o   = s_ack_i && !s_err_i;
                m0_err_o   = s_err_i || timeout;
                m0_dat_o   = s_dat_i;
            end
        end
    end

    // Arbitration, ownership release/abort and outstanding-strobe bookkeeping.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = prio_q ? OWN1 : OWN0;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (accept && !resp) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!accept && resp && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (timeout) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                    prio_d  = !own_sel;
                end else if (!own_cyc) begin
                    // Releasing owner loses the next tie.
                    state_d = (cnt_q != '0) ? ABORT : IDLE;
                    cnt_d   = '0;
                    prio_d  = !own_sel;
                end
            end
            ABORT: begin
                // Late responses land here and are dropped.
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, round-robin pointer and outstanding counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
